// File: rtl/perm_xor_cipher.sv
// Multi-round permute-then-XOR cipher over a W-bit word (per 8-bit lane), encrypt/decrypt, with valid/ready handshakes.
// Optional feature: define CIPHER_CNT_EN to add the blk_cnt handshake counter and its cnt_clr input.
module perm_xor_cipher #(
  parameter int W      = 8,
  parameter int ROUNDS = 3,
  parameter int KIW    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic           clock,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   din,
  input  logic           mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   dout,
  input  logic           key_we,
  input  logic [KIW-1:0] key_idx,
  input  logic [W-1:0]   key_wdata,
  output logic           busy
`ifdef CIPHER_CNT_EN
  ,
  input  logic           cnt_clr,
  output logic [15:0]    blk_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int             LANES = W / 8;
  localparam logic [KIW-1:0] LAST  = KIW'(ROUNDS - 1);

  state_t         state;
  logic [KIW-1:0] cnt;
  logic [W-1:0]   work;
  logic           dec;
  logic [W-1:0]   key [ROUNDS];
  logic [W-1:0]   round_key;
  logic [W-1:0]   next_work;

  function automatic logic [7:0] default_key(input int r);
    case (r)
      0:       default_key = 8'h3E;
      1:       default_key = 8'h49;
      2:       default_key = 8'h7E;
      default: default_key = 8'h00;
    endcase
  endfunction

  function automatic logic [W-1:0] p_word(input logic [W-1:0] x);
    logic [7:0] b;
    p_word = '0;
    for (int l = 0; l < LANES; l++) begin
      b = x[8*l +: 8];
      p_word[8*l +: 8] = {b[0], b[5], b[2], b[6], b[7], b[4], b[3], b[1]};
    end
  endfunction

  function automatic logic [W-1:0] pinv_word(input logic [W-1:0] x);
    logic [7:0] b;
    pinv_word = '0;
    for (int l = 0; l < LANES; l++) begin
      b = x[8*l +: 8];
      pinv_word[8*l +: 8] = {b[3], b[4], b[6], b[2], b[1], b[5], b[0], b[7]};
    end
  endfunction

  // Decrypt walks the key bank backwards so it undoes encrypt round by round.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    round_key = key[cnt];
    next_work = p_word(work) ^ round_key;
    if (dec) begin
      round_key = key[LAST - cnt];
      next_work = pinv_word(work ^ round_key);
    end
  end

  assign in_ready = (state == IDLE) || (state == DONE && out_ready);

  // NOTE: the key bank is a small register file with defined reset contents, so it is reset like any other state.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROUNDS; r++) key[r] <= {LANES{default_key(r)}};
    end else if (key_we && state == IDLE && key_idx <= LAST) begin
      key[key_idx] <= key_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      dec       <= 1'b0;
      dout      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= din;
            dec   <= mode;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          work <= next_work;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            dout      <= next_work;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work  <= din;
              dec   <= mode;
              cnt   <= '0;
              state <= RUN;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CIPHER_CNT_EN
  // Clear has priority over a coincident handshake.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      blk_cnt <= '0;
    end else if (cnt_clr) begin
      blk_cnt <= '0;
    end else if (out_valid && out_ready) begin
      blk_cnt <= blk_cnt + 16'd1;
    end
  end
`endif

endmodule
